// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared types, defaults and bit helpers for the NTT address generator
//
// Contents:
//   state_t          controller state encoding (IDLE, RUN, FIN, ERR)
//   N_LOG_MAX_DEF    default maximum log2 transform size
//   FN_W             working width of the helper functions
//   insert_zero_bit  returns x with a 0 bit inserted at position pos
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int N_LOG_MAX_DEF = 12;
  localparam int FN_W          = 32;

  // Bits below pos stay in place, bits at pos and above move up by one.
  function automatic logic [FN_W-1:0] insert_zero_bit(input logic [FN_W-1:0] x,
                                                      input logic [31:0]     pos);
    logic [FN_W-1:0] low_mask;
    low_mask = (FN_W'(1) << pos) - FN_W'(1);
    return ((x & ~low_mask) << 1) | (x & low_mask);
  endfunction

endpackage

// File: rtl/ntt_addr_lane.sv
// rtl/ntt_addr_lane.sv - combinational butterfly index to (u, v, w) address mapping for one lane
//
// Ports:
//   bl     in   N_LOG_MAX  butterfly index for this lane
//   s      in   NLW        stage number (1..n_log)
//   n_log  in   NLW        log2 transform size
//   u      out  N_LOG_MAX  upper operand address
//   v      out  N_LOG_MAX  lower operand address (u + half_m)
//   w      out  N_LOG_MAX  twiddle index
import ntt_pkg::*;

module ntt_addr_lane #(
  parameter int N_LOG_MAX = N_LOG_MAX_DEF,
  parameter int NLW       = $clog2(N_LOG_MAX + 1)
) (
  input  logic [N_LOG_MAX-1:0] bl,
  input  logic [NLW-1:0]       s,
  input  logic [NLW-1:0]       n_log,
  output logic [N_LOG_MAX-1:0] u,
  output logic [N_LOG_MAX-1:0] v,
  output logic [N_LOG_MAX-1:0] w
);

  logic [N_LOG_MAX-1:0] half_m;
  logic [N_LOG_MAX-1:0] j;

  always_comb begin
    half_m = N_LOG_MAX'(1) << (s - NLW'(1));
    j      = bl & (half_m - N_LOG_MAX'(1));
    u      = N_LOG_MAX'(insert_zero_bit(FN_W'(bl), 32'(s - NLW'(1))));
    v      = u | half_m;
    // Out-of-range shift (only possible with illegal inputs in IDLE) yields 0.
    w      = j << (n_log - s);
  end

endmodule

// File: rtl/ntt_addr_gen.sv
// rtl/ntt_addr_gen.sv - runtime-sized forward/inverse NTT butterfly address generator
//
// Optional feature macro: NTT_ADDR_GEN_STALL_CNT_EN (adds the stall_cnt output).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, inverse, n_log    transform request, mode and log2 size (sampled in IDLE)
//   ready                    downstream accepts the current beat
//   addr_u, addr_v, addr_w   per-lane operand/twiddle addresses, lane 0 in the LSBs
//   stage, inv_out           current stage and latched mode
//   valid, last              beat present / final beat of the transform
//   busy, done, err          not idle / end-of-transform pulse / illegal-size pulse
//   stall_cnt                cycles with valid && !ready (macro builds only)
import ntt_pkg::*;

module ntt_addr_gen #(
  parameter int N_LOG_MAX = N_LOG_MAX_DEF,
  parameter int LANES     = 1,
  parameter int NLW       = $clog2(N_LOG_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       inverse,
  input  logic [NLW-1:0]             n_log,
  input  logic                       ready,
  output logic [LANES*N_LOG_MAX-1:0] addr_u,
  output logic [LANES*N_LOG_MAX-1:0] addr_v,
  output logic [LANES*N_LOG_MAX-1:0] addr_w,
  output logic [NLW-1:0]             stage,
  output logic                       inv_out,
  output logic                       valid,
  output logic                       last,
  output logic                       busy,
  output logic                       done,
  output logic                       err
`ifdef NTT_ADDR_GEN_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cnt
`endif
);

  localparam logic [31:0]          NMAX_U    = 32'(N_LOG_MAX);
  localparam logic [31:0]          LANES_LOG = 32'($clog2(LANES));
  localparam logic [N_LOG_MAX-1:0] LANES_W   = N_LOG_MAX'(LANES);

  state_t               state;
  logic [N_LOG_MAX-1:0] b_q;
  logic [NLW-1:0]       nlog_q;

  // Cursor of the beat to be presented next; its addresses are computed
  // by the lanes and captured into the output registers on load.
  logic [N_LOG_MAX-1:0] nb;
  logic [N_LOG_MAX-1:0] half_n;
  logic [NLW-1:0]       ns;
  logic [NLW-1:0]       nl;
  logic [NLW-1:0]       final_s;
  logic                 nmode;
  logic                 nlast;
  logic                 legal;
  logic                 load;

  logic [LANES*N_LOG_MAX-1:0] nu;
  logic [LANES*N_LOG_MAX-1:0] nv;
  logic [LANES*N_LOG_MAX-1:0] nw;

  always_comb begin
    // LANES is a power of two, so 2^n_log >= 2*LANES <=> n_log > log2(LANES).
    legal = (n_log != '0) && (32'(n_log) <= NMAX_U) && (32'(n_log) > LANES_LOG);
    nb    = '0;
    ns    = stage;
    if (state == IDLE) begin
      nl     = n_log;
      nmode  = inverse;
      half_n = N_LOG_MAX'(1) << (nl - NLW'(1));
      ns     = inverse ? n_log : NLW'(1);
    end else begin
      nl     = nlog_q;
      nmode  = inv_out;
      half_n = N_LOG_MAX'(1) << (nl - NLW'(1));
      if (b_q + LANES_W == half_n) begin
        ns = inv_out ? (stage - NLW'(1)) : (stage + NLW'(1));
      end else begin
        nb = b_q + LANES_W;
      end
    end
    final_s = nmode ? NLW'(1) : nl;
    nlast   = (ns == final_s) && (nb == half_n - LANES_W);
    load    = ((state == IDLE) && start && legal) ||
              ((state == RUN) && valid && ready && !last);
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ntt_addr_lane #(
      .N_LOG_MAX (N_LOG_MAX),
      .NLW       (NLW)
    ) u_lane (
      .bl    (nb + N_LOG_MAX'(l)),
      .s     (ns),
      .n_log (nl),
      .u     (nu[l*N_LOG_MAX +: N_LOG_MAX]),
      .v     (nv[l*N_LOG_MAX +: N_LOG_MAX]),
      .w     (nw[l*N_LOG_MAX +: N_LOG_MAX])
    );
  end

  // Control FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef NTT_ADDR_GEN_STALL_CNT_EN
      stall_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef NTT_ADDR_GEN_STALL_CNT_EN
            stall_cnt <= '0;
`endif
            if (legal) begin
              state <= RUN;
              valid <= 1'b1;
            end else begin
              state <= ERR;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (valid && ready && last) begin
            state <= FIN;
            valid <= 1'b0;
            done  <= 1'b1;
          end
`ifdef NTT_ADDR_GEN_STALL_CNT_EN
          if (valid && !ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
          end
`endif
        end
        FIN, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat datapath: everything here is held while a beat is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q     <= '0;
      nlog_q  <= '0;
      stage   <= '0;
      inv_out <= 1'b0;
      last    <= 1'b0;
      addr_u  <= '0;
      addr_v  <= '0;
      addr_w  <= '0;
    end else if (load) begin
      b_q     <= nb;
      nlog_q  <= nl;
      stage   <= ns;
      inv_out <= nmode;
      last    <= nlast;
      addr_u  <= nu;
      addr_v  <= nv;
      addr_w  <= nw;
    end else if ((state == RUN) && valid && ready) begin
      last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ntt_addr_gen.sv
// tb/tb_ntt_addr_gen.sv - self-checking bench for ntt_addr_gen (LANES=1/N=3 and LANES=2/N=4 instances)
module tb_ntt_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a;
  logic       start_b;
  logic       inverse;
  logic [2:0] n_log_in;
  logic       ready;

  logic [2:0] a_u, a_v, a_w, a_stage;
  logic       a_inv, a_valid, a_last, a_busy, a_done, a_err;
  logic [7:0] b_u, b_v, b_w;
  logic [2:0] b_stage;
  logic       b_inv, b_valid, b_last, b_busy, b_done, b_err;
`ifdef NTT_ADDR_GEN_STALL_CNT_EN
  logic [31:0] a_stall, b_stall, mon_stall;
`endif

  ntt_addr_gen #(.N_LOG_MAX(3), .LANES(1), .NLW(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .inverse(inverse), .n_log(n_log_in),
    .ready(ready), .addr_u(a_u), .addr_v(a_v), .addr_w(a_w), .stage(a_stage),
    .inv_out(a_inv), .valid(a_valid), .last(a_last), .busy(a_busy),
    .done(a_done), .err(a_err)
`ifdef NTT_ADDR_GEN_STALL_CNT_EN
    , .stall_cnt(a_stall)
`endif
  );

  ntt_addr_gen #(.N_LOG_MAX(4), .LANES(2), .NLW(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .inverse(inverse), .n_log(n_log_in),
    .ready(ready), .addr_u(b_u), .addr_v(b_v), .addr_w(b_w), .stage(b_stage),
    .inv_out(b_inv), .valid(b_valid), .last(b_last), .busy(b_busy),
    .done(b_done), .err(b_err)
`ifdef NTT_ADDR_GEN_STALL_CNT_EN
    , .stall_cnt(b_stall)
`endif
  );

  bit         sel_mon;
  logic [7:0] mon_u, mon_v, mon_w;
  logic [2:0] mon_stage;
  logic       mon_inv, mon_valid, mon_last, mon_busy, mon_done, mon_err;

  always_comb begin
    if (sel_mon) begin
      mon_u = b_u; mon_v = b_v; mon_w = b_w; mon_stage = b_stage;
      mon_inv = b_inv; mon_valid = b_valid; mon_last = b_last;
      mon_busy = b_busy; mon_done = b_done; mon_err = b_err;
`ifdef NTT_ADDR_GEN_STALL_CNT_EN
      mon_stall = b_stall;
`endif
    end else begin
      mon_u = {5'b0, a_u}; mon_v = {5'b0, a_v}; mon_w = {5'b0, a_w}; mon_stage = a_stage;
      mon_inv = a_inv; mon_valid = a_valid; mon_last = a_last;
      mon_busy = a_busy; mon_done = a_done; mon_err = a_err;
`ifdef NTT_ADDR_GEN_STALL_CNT_EN
      mon_stall = a_stall;
`endif
    end
  end

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] u, v, w;
    int         s;
    bit         l;
  } beat_t;

  typedef struct {
    bit inv;
    int u, v, w, s;
  } vec_t;

  beat_t exp_q[$];
  vec_t  tab[24];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference schedule from the addressing rules, using div/mod arithmetic.
  task automatic build_model(input bit sel, input bit inv, input int nl);
    int lanes = sel ? 2 : 1;
    int nmax  = sel ? 4 : 3;
    int half  = 1 << (nl - 1);
    exp_q.delete();
    for (int k = 0; k < nl; k++) begin
      int s  = inv ? nl - k : k + 1;
      int hm = 1 << (s - 1);
      for (int b = 0; b < half; b += lanes) begin
        beat_t e;
        e.u = 0; e.v = 0; e.w = 0; e.s = s;
        e.l = (k == nl - 1) && (b == half - lanes);
        for (int l = 0; l < lanes; l++) begin
          int bl = b + l;
          int j  = bl % hm;
          int u  = (bl / hm) * 2 * hm + j;
          int v  = u + hm;
          int w  = j * (1 << (nl - s));
          e.u = e.u | 8'(u << (l * nmax));
          e.v = e.v | 8'(v << (l * nmax));
          e.w = e.w | 8'(w << (l * nmax));
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_start(input bit sel, input bit inv, input int nl);
    sel_mon  = sel;
    inverse  = inv;
    n_log_in = 3'(nl);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // mode 0: ready=1; 1: random ready plus ignored start pulses and input churn;
  // 2: ready low for 3 cycles on beat 5. stop_after >= 0 abandons at that beat.
  task automatic run_xfer(input bit sel, input bit inv, input int nl, input int mode,
                          input int stop_after, input bit use_model, input string tag);
    int beats = 0;
    int cyc = 0;
    int stalls = 0;
    int hold = 0;
    if (use_model) build_model(sel, inv, nl);
    do_start(sel, inv, nl);
    chk($sformatf("%s busy", tag), 64'(mon_busy), 64'(1));
    chk($sformatf("%s inv_out", tag), 64'(mon_inv), 64'(inv));
    while (exp_q.size() > 0 && cyc < 2000) begin
      if (stop_after >= 0 && beats == stop_after) return;
      chk($sformatf("%s beat%0d", tag, beats),
          64'({mon_valid, mon_u, mon_v, mon_w, mon_stage, mon_last}),
          64'({1'b1, exp_q[0].u, exp_q[0].v, exp_q[0].w, 3'(exp_q[0].s), exp_q[0].l}));
      ready = 1'b1;
      if (mode == 1) begin
        ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) begin
          if (sel) start_b = 1'b1; else start_a = 1'b1;
          inverse  = 1'($urandom);
          n_log_in = 3'($urandom);
        end else begin
          start_a = 1'b0;
          start_b = 1'b0;
        end
      end else if (mode == 2 && beats == 5 && hold < 3) begin
        ready = 1'b0;
        hold++;
      end
      if (ready) begin
        void'(exp_q.pop_front());
        beats++;
      end else begin
        stalls++;
      end
      cyc++;
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    ready   = 1'b1;
    chk($sformatf("%s complete", tag), 64'(exp_q.size()), 64'(0));
    chk($sformatf("%s fin", tag), 64'({mon_valid, mon_done, mon_err, mon_busy}), 64'(4'b0101));
    @(negedge clk);
    chk($sformatf("%s idle", tag), 64'({mon_valid, mon_done, mon_err, mon_busy}), 64'(4'b0000));
`ifdef NTT_ADDR_GEN_STALL_CNT_EN
    chk($sformatf("%s stall_cnt", tag), 64'(mon_stall), 64'(stalls));
`endif
  endtask

  task automatic err_xfer(input bit sel, input int nl);
    do_start(sel, 1'b0, nl);
    chk($sformatf("err pulse sel%0d n%0d", sel, nl),
        64'({mon_valid, mon_done, mon_err, mon_busy}), 64'(4'b0111));
    @(negedge clk);
    chk($sformatf("err idle sel%0d n%0d", sel, nl),
        64'({mon_valid, mon_done, mon_err, mon_busy}), 64'(4'b0000));
  endtask

  initial begin
    // N_LOG_MAX=3, n_log=3, LANES=1 schedules: forward 0..11, inverse 12..23.
    tab[0]  = '{0, 0, 1, 0, 1}; tab[1]  = '{0, 2, 3, 0, 1};
    tab[2]  = '{0, 4, 5, 0, 1}; tab[3]  = '{0, 6, 7, 0, 1};
    tab[4]  = '{0, 0, 2, 0, 2}; tab[5]  = '{0, 1, 3, 2, 2};
    tab[6]  = '{0, 4, 6, 0, 2}; tab[7]  = '{0, 5, 7, 2, 2};
    tab[8]  = '{0, 0, 4, 0, 3}; tab[9]  = '{0, 1, 5, 1, 3};
    tab[10] = '{0, 2, 6, 2, 3}; tab[11] = '{0, 3, 7, 3, 3};
    tab[12] = '{1, 0, 4, 0, 3}; tab[13] = '{1, 1, 5, 1, 3};
    tab[14] = '{1, 2, 6, 2, 3}; tab[15] = '{1, 3, 7, 3, 3};
    tab[16] = '{1, 0, 2, 0, 2}; tab[17] = '{1, 1, 3, 2, 2};
    tab[18] = '{1, 4, 6, 0, 2}; tab[19] = '{1, 5, 7, 2, 2};
    tab[20] = '{1, 0, 1, 0, 1}; tab[21] = '{1, 2, 3, 0, 1};
    tab[22] = '{1, 4, 5, 0, 1}; tab[23] = '{1, 6, 7, 0, 1};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; inverse = 1'b0;
    n_log_in = 3'd0; ready = 1'b1; sel_mon = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset a", 64'({a_u, a_v, a_w, a_stage, a_inv, a_valid, a_last, a_busy, a_done, a_err}), 64'(0));
    chk("reset b", 64'({b_u, b_v, b_w, b_stage, b_inv, b_valid, b_last, b_busy, b_done, b_err}), 64'(0));
`ifdef NTT_ADDR_GEN_STALL_CNT_EN
    chk("reset stall", 64'({a_stall, b_stall}), 64'(0));
`endif
    rst = 1'b0;
    @(negedge clk);

    // Table vectors: forward then inverse.
    for (int m = 0; m < 2; m++) begin
      exp_q.delete();
      for (int i = 0; i < 12; i++) begin
        beat_t e;
        e.u = 8'(tab[m*12+i].u); e.v = 8'(tab[m*12+i].v); e.w = 8'(tab[m*12+i].w);
        e.s = tab[m*12+i].s; e.l = (i == 11);
        exp_q.push_back(e);
      end
      run_xfer(1'b0, tab[m*12].inv, 3, 0, -1, 1'b0, m ? "tab_inv" : "tab_fwd");
    end

    // LANES=2, n_log=3 forward: lanes pair consecutive forward table entries.
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      beat_t e;
      e.u = 8'(tab[2*k].u | (tab[2*k+1].u << 4));
      e.v = 8'(tab[2*k].v | (tab[2*k+1].v << 4));
      e.w = 8'(tab[2*k].w | (tab[2*k+1].w << 4));
      e.s = tab[2*k].s; e.l = (k == 5);
      exp_q.push_back(e);
    end
    run_xfer(1'b1, 1'b0, 3, 0, -1, 1'b0, "lanes2");

    // Backpressure at beat 5.
    run_xfer(1'b0, 1'b0, 3, 2, -1, 1'b1, "bp");

    // Illegal sizes.
    err_xfer(1'b0, 0);
    err_xfer(1'b0, 4);
    err_xfer(1'b1, 1);
    err_xfer(1'b1, 5);

    // Reset mid-transform at beat 7, then a clean restart.
    run_xfer(1'b0, 1'b0, 3, 0, 7, 1'b1, "pre_rst");
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset outputs",
        64'({a_u, a_v, a_w, a_stage, a_inv, a_valid, a_last, a_busy, a_done, a_err}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("no done after reset", 64'({a_done, a_valid, a_busy}), 64'(0));
    run_xfer(1'b0, 1'b0, 3, 0, -1, 1'b1, "post_rst");

    // Randomized transfers against the reference model.
    for (int it = 0; it < 24; it++) begin
      bit sel = 1'($urandom_range(0, 1));
      int nl  = sel ? int'($urandom_range(2, 4)) : int'($urandom_range(1, 3));
      bit inv = 1'($urandom_range(0, 1));
      run_xfer(sel, inv, nl, 1, -1, 1'b1, $sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ntt_addr_gen.md
# ntt_addr_gen

Parametrised NTT butterfly address generator, the successor to the single-mode fixed-size NTT controller. It is runtime-configurable in transform size (2^n_log, up to 2^N_LOG_MAX) and handles forward (Cooley–Tukey, stages ascending) and inverse (Gentleman–Sande, stages descending) schedules. Each beat issues LANES butterflies. Downstream backpressure uses a valid/ready handshake. It sits between the NTT sequencer and the coefficient-RAM / twiddle-ROM read ports of the butterfly datapath.

## Interface
- N_LOG_MAX, 12: maximum log2 transform size; address width.
- LANES, 1: butterflies per beat; power of two, 1..2^(N_LOG_MAX-1).
- NLW, $clog2(N_LOG_MAX+1): width of n_log and stage.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin transform; sampled only in IDLE.
- inverse  in  1  mode, sampled with start: 0 forward, 1 inverse.
- n_log  in  NLW  log2 transform size, sampled with start.
- ready  in  1  downstream accepts the current beat.
- addr_u  out  LANES*N_LOG_MAX  upper operand address per lane; lane 0 in the LSBs.
- addr_v  out  LANES*N_LOG_MAX  lower operand address per lane.
- addr_w  out  LANES*N_LOG_MAX  twiddle index per lane.
- stage  out  NLW  current stage s (1..n_log).
- inv_out  out  1  latched mode, for twiddle-table select.
- valid  out  1  beat present.
- last  out  1  final beat of the transform, qualified by valid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the final handshake.
- err  out  1  one-cycle pulse, concurrent with done, for an illegal n_log.
- stall_cnt  out  32  present only with NTT_ADDR_GEN_STALL_CNT_EN.

## Operation
- States:
  - IDLE: start moves to RUN, or to ERR if n_log is illegal.
  - RUN: advances on each handshake. The final handshake moves to FIN.
  - FIN: done=1, then IDLE.
  - ERR: done=1, err=1, then IDLE.
- Illegal n_log: 0, greater than N_LOG_MAX, or 2^n_log < 2*LANES.
- Butterfly counter b runs 0..2^(n_log-1)-1 per stage and increments by LANES per handshake.
- Lane l uses bl = b+l. For stage s, with half_m = 2^(s-1):
  - j = bl & (half_m-1).
  - u = bl with a 0 bit inserted at position s-1.
  - v = u | half_m.
  - w = j << (n_log - s).
- All arithmetic is unsigned at N_LOG_MAX bits. Unused high address bits are 0.
- Stage order is 1..n_log when forward and n_log..1 when inverse. b resets to 0 at each stage boundary.
- Beats per transform: n_log * 2^(n_log-1) / LANES.
- last=1 only on the beat with the final stage and b = 2^(n_log-1)-LANES.
- start in RUN, FIN or ERR is ignored. inverse and n_log are latched at start; later changes have no effect.

## Timing
- All outputs are registered.
- Reset: valid, last, busy, done, err, stage, inv_out and all addr_* are 0. State is IDLE. stall_cnt is 0.
- Start accepted at edge t: valid=1 with beat 0 from t+1.
- While valid && !ready, all outputs are held stable.
- On valid && ready, the next beat appears the following cycle. There are no bubbles between beats while ready=1.
- Final handshake at edge t: valid=0 at t+1 and done=1 for exactly cycle t+1 (FIN). IDLE from t+2; start sampled at t+2 is accepted.
- ERR path: start at edge t gives done=err=1 at t+1. valid is never asserted.
- rst asserted mid-transform: at the next edge all outputs are at reset values. No done pulse is produced.

## Configuration
- NTT_ADDR_GEN_STALL_CNT_EN defined:
  - stall_cnt counts cycles with valid && !ready, saturating at 2^32-1.
  - It clears on accepted start and holds its value after done.
- NTT_ADDR_GEN_STALL_CNT_EN undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Package ntt_pkg holds:
  - the state enum typedef (IDLE, RUN, FIN, ERR);
  - N_LOG_MAX default;
  - the insert-zero-bit function.
- Sub-module ntt_addr_lane: combinational mapping of (bl, s, n_log) to (u, v, w). It is instantiated LANES times and its outputs are registered in the parent.

## Test plan
- Forward, N_LOG_MAX=3, n_log=3, LANES=1, ready=1:
  - Stage 1 (u,v,w): (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - Stage 2: (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - Stage 3: (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - 12 beats, last on beat 12, done one cycle later.
- Inverse, same config: stage outputs 3,3,3,3,2,…,1. First beat (0,4,0); beat 5 (0,2,0); last beat (6,7,0); inv_out=1.
- LANES=2, n_log=3 forward: beat 0 has lane 0 (0,1,0) and lane 1 (2,3,0). 6 beats total.
- Backpressure: ready=0 for 3 cycles at beat 5. Outputs are held unchanged; the sequence is otherwise identical; stall_cnt=3 when the macro is defined.
- Illegal n_log: n_log=0 (and n_log=4 with N_LOG_MAX=3) gives done=err=1 one cycle after start, with valid never asserted.
- Robustness:
  - start pulsed mid-transform is ignored.
  - rst at beat 7 gives all outputs 0 next cycle and no done.
  - A new start then gives a clean beat 0.
